// File: rtl/skin_ellipse_cls_if.sv
// Pixel stream into the skin classifier, and the classification and frame-count results out of it.
interface skin_ellipse_cls_if #(
  parameter int CNT_W = 20
);
  logic             in_valid;
  logic             in_sof;
  logic             in_eof;
  logic [7:0]       in_cb;
  logic [7:0]       in_cr;
  logic             out_valid;
  logic             out_skin;
  logic             out_sof;
  logic             out_eof;
  logic [CNT_W-1:0] frame_skin_count;
  logic             count_valid;

  // Pixel source side: drives the chroma stream and receives the results.
  modport master (
    output in_valid, in_sof, in_eof, in_cb, in_cr,
    input  out_valid, out_skin, out_sof, out_eof, frame_skin_count, count_valid
  );

  // Classifier side.
  modport slave (
    input  in_valid, in_sof, in_eof, in_cb, in_cr,
    output out_valid, out_skin, out_sof, out_eof, frame_skin_count, count_valid
  );
endinterface

// File: rtl/skin_ellipse_cls.sv
// Skin classifier: rotated elliptical cluster test in the Cb'-Cr' plane,
// 5-stage streaming pipeline with a per-frame skin-pixel counter.
module skin_ellipse_cls #(
  parameter int CX    = 109,
  parameter int CY    = 152,
  parameter int COS_Q = -210,
  parameter int SIN_Q = 147,
  parameter int ECX   = 2,
  parameter int ECY   = 2,
  parameter int A2    = 625,
  parameter int B2    = 196,
  parameter int AB2   = 122500,
  parameter int CNT_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  skin_ellipse_cls_if.slave  bus
);

  localparam logic signed [18:0] COS_W = 19'(COS_Q);
  localparam logic signed [18:0] SIN_W = 19'(SIN_Q);

  logic signed [8:0]  s1_dcb, s1_dcr;
  logic signed [18:0] s2_px, s2_py;
  logic signed [11:0] s3_x, s3_y;
  logic [21:0]        s4_x2, s4_y2;
  logic [33:0]        e_c;
  logic               skin_c;

  logic s1_v, s2_v, s3_v, s4_v;
  logic s1_sof, s2_sof, s3_sof, s4_sof;
  logic s1_eof, s2_eof, s3_eof, s4_eof;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_sum;
  logic [CNT_W-1:0] frame_cnt;

  // Arithmetic datapath: centre offset, rotation, rescale/shift, squaring.
  always_ff @(posedge clk) begin
    s1_dcb <= $signed({1'b0, bus.in_cb}) - 9'(CX);
    s1_dcr <= $signed({1'b0, bus.in_cr}) - 9'(CY);
    s2_px  <= COS_W * 19'(s1_dcb) + SIN_W * 19'(s1_dcr);
    s2_py  <= COS_W * 19'(s1_dcr) - SIN_W * 19'(s1_dcb);
    s3_x   <= 12'(s2_px >>> 8) - 12'(ECX);
    s3_y   <= 12'(s2_py >>> 8) - 12'(ECY);
    s4_x2  <= 22'(s3_x) * 22'(s3_x);
    s4_y2  <= 22'(s3_y) * 22'(s3_y);
  end

  // Final ellipse test evaluated ahead of the output register so the counter
  // can fold in the current pixel on the same edge that raises out_valid.
  always_comb begin
    e_c    = 34'(B2) * 34'(s4_x2) + 34'(A2) * 34'(s4_y2);
    skin_c = (e_c <= 34'(AB2));
  end

  // Saturating running count; sof restarts it from this pixel.
  always_comb begin
    cnt_base = s4_sof ? '0 : cnt;
    cnt_sum  = cnt_base;
    if (skin_c && (cnt_base != '1))
      cnt_sum = cnt_base + CNT_W'(1);
  end

  // Valid/frame tags, registered outputs and frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {s1_v, s2_v, s3_v, s4_v}         <= '0;
      {s1_sof, s2_sof, s3_sof, s4_sof} <= '0;
      {s1_eof, s2_eof, s3_eof, s4_eof} <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_skin    <= 1'b0;
      bus.out_sof     <= 1'b0;
      bus.out_eof     <= 1'b0;
      bus.count_valid <= 1'b0;
      cnt             <= '0;
      frame_cnt       <= '0;
    end else begin
      s1_v   <= bus.in_valid;
      s1_sof <= bus.in_sof;
      s1_eof <= bus.in_eof;
      s2_v   <= s1_v;   s2_sof <= s1_sof; s2_eof <= s1_eof;
      s3_v   <= s2_v;   s3_sof <= s2_sof; s3_eof <= s2_eof;
      s4_v   <= s3_v;   s4_sof <= s3_sof; s4_eof <= s3_eof;
      bus.out_valid   <= s4_v;
      bus.out_skin    <= skin_c;
      bus.out_sof     <= s4_sof;
      bus.out_eof     <= s4_eof;
      bus.count_valid <= s4_v & s4_eof;
      if (s4_v) begin
        cnt <= cnt_sum;
        if (s4_eof)
          frame_cnt <= cnt_sum;
      end
    end
  end

  assign bus.frame_skin_count = frame_cnt;

endmodule

// File: tb/tb_skin_ellipse_cls.sv
// Scoreboard bench for skin_ellipse_cls: expected pixel results and frame
// counts are queued at drive time and compared when out_valid appears.
module tb_skin_ellipse_cls;

  localparam int CNT_W = 20;

  logic clk;
  logic rst_n;

  skin_ellipse_cls_if #(.CNT_W(CNT_W)) bus ();

  skin_ellipse_cls #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        skin;
    logic        sof;
    logic        eof;
    logic        cv;
    int unsigned frame;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned n_cv;
  int unsigned mcnt;
  int unsigned pulses0;
  bit          mon_en;

  task automatic check(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Integer reference: floor shift, rotated offset, ellipse inequality.
  function automatic logic model_skin(input int cb, input int cr);
    int     dcb, dcr, px, py, x, y;
    longint e;
    dcb = cb - 109;
    dcr = cr - 152;
    px  = -210 * dcb + 147 * dcr;
    py  = -210 * dcr - 147 * dcb;
    x   = (px >>> 8) - 2;
    y   = (py >>> 8) - 2;
    e   = 196 * longint'(x * x) + 625 * longint'(y * y);
    return (e <= 122500);
  endfunction

  always @(posedge clk) cyc++;

  task automatic drive_pix(input logic [7:0] cb, input logic [7:0] cr,
                           input logic sof, input logic eof, input logic exp_skin);
    exp_t        e;
    int unsigned base;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_eof   = eof;
    bus.in_cb    = cb;
    bus.in_cr    = cr;
    base = sof ? 0 : mcnt;
    if (exp_skin && base < (2**CNT_W - 1)) base++;
    mcnt    = base;
    e.skin  = exp_skin;
    e.sof   = sof;
    e.eof   = eof;
    e.cv    = eof;
    e.frame = base;
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_eof   = 1'b0;
    end
  endtask

  // One-cycle reset; pixels whose output edge falls on or after it are lost.
  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
    while (sb.size() > 0 && sb[$].cyc + 5 > cyc) void'(sb.pop_back());
    mcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("latency", cyc, mon_e.cyc + 5);
          check("skin", bus.out_skin, mon_e.skin);
          check("sof", bus.out_sof, mon_e.sof);
          check("eof", bus.out_eof, mon_e.eof);
          check("count_valid", bus.count_valid, mon_e.cv);
          if (mon_e.cv) check("frame_count", bus.frame_skin_count, mon_e.frame);
        end
      end else begin
        check("cv_idle", bus.count_valid, 0);
      end
      if (bus.count_valid === 1'b1) n_cv++;
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; n_cv = 0; mcnt = 0; cyc = 0; mon_en = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eof   = 1'b0;
    bus.in_cb    = '0;
    bus.in_cr    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_skin", bus.out_skin, 0);
    check("rst_out_sof", bus.out_sof, 0);
    check("rst_out_eof", bus.out_eof, 0);
    check("rst_frame_count", bus.frame_skin_count, 0);
    check("rst_count_valid", bus.count_valid, 0);
    rst_n  = 1'b1;
    mon_en = 1;

    // Named points: centre, (0,0), (255,255)
    drive_pix(8'd109, 8'd152, 1'b0, 1'b0, 1'b1);
    drive_pix(8'd0,   8'd0,   1'b0, 1'b0, 1'b0);
    drive_pix(8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
    idle(8);

    // 10-pixel frame, skin at 2/5/9, gaps after pixel 4
    pulses0 = n_cv;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) idle(3);
      if (i == 2 || i == 5 || i == 9)
        drive_pix(8'd109, 8'd152, i == 0, i == 9, 1'b1);
      else
        drive_pix(8'd0, 8'd0, i == 0, i == 9, 1'b0);
    end
    idle(8);
    check("frame10_count", bus.frame_skin_count, 3);
    check("frame10_pulses", n_cv - pulses0, 1);

    // Reset with 3 pixels of a frame in flight
    pulses0 = n_cv;
    drive_pix(8'd109, 8'd152, 1'b1, 1'b0, 1'b1);
    drive_pix(8'd109, 8'd152, 1'b0, 1'b0, 1'b1);
    drive_pix(8'd109, 8'd152, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    idle(8);
    check("abort_pulses", n_cv - pulses0, 0);
    check("abort_frame_count", bus.frame_skin_count, 0);
    drive_pix(8'd109, 8'd152, 1'b1, 1'b0, 1'b1);
    drive_pix(8'd0,   8'd0,   1'b0, 1'b0, 1'b0);
    drive_pix(8'd109, 8'd152, 1'b0, 1'b0, 1'b1);
    drive_pix(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
    idle(8);
    check("post_abort_count", bus.frame_skin_count, 2);

    // Single-pixel frames
    pulses0 = n_cv;
    drive_pix(8'd109, 8'd152, 1'b1, 1'b1, 1'b1);
    idle(7);
    check("single_skin_count", bus.frame_skin_count, 1);
    drive_pix(8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    idle(7);
    check("single_bg_count", bus.frame_skin_count, 0);
    check("single_pulses", n_cv - pulses0, 2);

    // Exhaustive sweep as one back-to-back frame
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] v;
      v = 16'(i);
      drive_pix(v[15:8], v[7:0], i == 0, i == 65535, model_skin(int'(v[15:8]), int'(v[7:0])));
    end
    idle(8);
    check("sweep_frame_count", bus.frame_skin_count, mcnt);

    // Bounded drain
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    check("drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/skin_ellipse_cls.md
Name: skin_ellipse_cls

Overview:
Consumes the nonlinearly transformed chroma pair (Cb', Cr') from the transcb/transcr stages and classifies each pixel as skin or non-skin. It uses a rotated, fixed-point elliptical cluster test in the Cb'–Cr' plane. A per-frame skin-pixel counter is also kept, for the downstream face-region logic. The block is a fully pipelined streaming stage with valid tagging and no backpressure, matching the upstream stages.

Parameters:
CX, 109, ellipse centre on the Cb' axis (integer).
CY, 152, ellipse centre on the Cr' axis (integer).
COS_Q, -210, cos(theta) in signed Q1.8 format (theta = 2.53 rad).
SIN_Q, 147, sin(theta) in signed Q1.8 format.
ECX, 2, x offset of the ellipse centre after rotation (signed integer).
ECY, 2, y offset of the ellipse centre after rotation (signed integer).
A2, 625, squared semi-major axis (a^2).
B2, 196, squared semi-minor axis (b^2).
AB2, 122500, product A2*B2.
CNT_W, 20, width of the frame skin counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  the input pixel is valid this cycle.
in_sof  in  1  first pixel of a frame; qualified by in_valid.
in_eof  in  1  last pixel of a frame; qualified by in_valid.
in_cb  in  8  transformed Cb' (unsigned).
in_cr  in  8  transformed Cr' (unsigned).
out_valid  out  1  the classification result is valid.
out_skin  out  1  1 = the pixel lies inside or on the ellipse.
out_sof  out  1  in_sof delayed to align with out_valid.
out_eof  out  1  in_eof delayed to align with out_valid.
frame_skin_count  out  CNT_W  skin-pixel total of the last completed frame.
count_valid  out  1  one-cycle pulse when frame_skin_count updates.

Behaviour:
- Reset (rst_n=0 at a clock edge) clears all outputs, all pipeline valid/sof/eof bits and the running counter to 0 on that edge. Pipeline data registers need no reset.
- Reset mid-frame discards in-flight pixels. No count_valid pulse is generated for the aborted frame.
- Latency: exactly 5 cycles from in_valid to out_valid. A new pixel is accepted every cycle. in_sof and in_eof travel with their pixel.
- Pipeline stages:
  - S1: dcb = in_cb - CX; dcr = in_cr - CY. Both are 9-bit signed.
  - S2: px = COS_Q*dcb + SIN_Q*dcr; py = COS_Q*dcr - SIN_Q*dcb. Both are 19-bit signed.
  - S3: x = (px >>> 8) - ECX; y = (py >>> 8) - ECY. The shift is arithmetic (floor). Results are 12-bit signed.
  - S4: x2 = x*x and y2 = y*y, each 22-bit unsigned.
  - S5: e = B2*x2 + A2*y2, computed at 34 bits with no overflow. out_skin = (e <= AB2).
- Equality counts as skin.
- Data with in_valid=0 still propagates. Outputs are don't-care whenever out_valid=0.
- Counter (update only when out_valid=1):
  - running count: if out_sof, count = out_skin. Otherwise count = count + out_skin.
  - The count saturates at 2^CNT_W - 1 and does not wrap.
  - If out_eof: frame_skin_count is set, on the same edge, to the running count including this pixel (out_sof accounted for). count_valid = 1 for that one cycle. The running count is then don't-care until the next sof.
  - out_sof and out_eof on the same pixel (single-pixel frame): frame_skin_count = out_skin and count_valid pulses.
  - out_eof with no preceding sof since reset: the count accumulates from the reset value 0.
  - A gap cycle (out_valid=0) leaves the counter and frame_skin_count unchanged, and count_valid=0.
- frame_skin_count holds its value until the next eof.

Test Plan:
- Reset, then (Cb',Cr')=(109,152) with in_valid=1. x=-2, y=-2, e=3284. Required: out_valid=1 and out_skin=1 exactly 5 cycles later; all outputs 0 during reset.
- Input (0,0): x=0, y=185. Required: out_skin=0. Input (255,255): x=-63, y=-171. Required: out_skin=0.
- Exhaustive sweep of all 65536 (Cb',Cr') pairs back-to-back. Required: every out_skin bit-exact against the integer reference model (including equality at e == AB2), and no bubbles.
- Frame of 10 pixels with sof on pixel 0 and eof on pixel 9; pixels 2, 5 and 9 are (109,152), the rest (0,0). Insert in_valid gaps after pixel 4. Required: count_valid pulses once, aligned with pixel 9's out_valid; frame_skin_count=3.
- Single-pixel frame (sof=eof=1) at (109,152), then one at (0,0). Required: frame_skin_count=1, then 0, with two count_valid pulses.
- Assert rst_n=0 for one cycle while 3 pixels are in flight mid-frame. Required: no out_valid for those pixels, count_valid stays 0, frame_skin_count=0; the next full frame counts correctly from 0.
